uart_rx_ctrl: RTL

//  Receive-side frame controller for the UART RX path; sits directly downstream of edge_bit_cnt.
//  - Drives the counter's enable and consumes edge_cnt/bit_cnt.
//  - Majority-votes rx_in around mid-bit and walks the frame: start, 8 data bits, optional parity, stop.
//  - Deserialises the byte LSB-first and emits p_data with a 1-cycle data_valid to the RX data sync.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_ctrl_sampler.sv | 41 ++++
 rtl/uart_rx_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame controller.
// Holds the FSM state encoding, parity-type constants, datapath widths
// and a 3-input majority helper used by the sampler.
package uart_rx_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned PRESC_W = 6;
    localparam int unsigned BIT_W   = 4;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_sampler.sv
// rx_majority_sampler: captures rx_in at edge_cnt == P/2-2, P/2-1, P/2
// and presents the majority of the three samples.
// Ports:
//   clk, rst   clock, async active-high reset
//   rx_in      serial line (synchronous to clk)
//   edge_cnt   oversample tick within the current bit
//   prescale   latched oversampling ratio P
//   vote_c     combinational majority of the three sample flops
module rx_majority_sampler
    import uart_rx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic [PRESC_W-1:0] prescale,
    output logic               vote_c
);

    logic [2:0]         samp_q;
    logic [2:0]         samp_d;
    logic [PRESC_W-1:0] half;

    assign half = prescale >> 1;

    // Sample window is centred on mid-bit.
    always_comb begin
        samp_d = samp_q;
        if (edge_cnt == half - PRESC_W'(2)) samp_d[0] = rx_in;
        if (edge_cnt == half - PRESC_W'(1)) samp_d[1] = rx_in;
        if (edge_cnt == half)               samp_d[2] = rx_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) samp_q <= '0;
        else     samp_q <= samp_d;
    end

    assign vote_c = maj3(samp_q[0], samp_q[1], samp_q[2]);

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller downstream of edge_bit_cnt.
// Walks start / 8 data (LSB-first) / optional parity / stop, using a
// majority vote around mid-bit, and emits p_data with a 1-cycle data_valid.
// Optional feature macro: RX_ERR_CHECK_EN (parity/stop error checking;
// when undefined par_err/stp_err stay 0 and every accepted frame is valid).
// Ports:
//   clk, rst             clock, async active-high reset
//   rx_in                serial line, idle high
//   prescale             oversampling ratio (4/8/16/32), latched at frame start
//   par_en, par_typ      parity present / 0 even 1 odd, latched at frame start
//   edge_cnt, bit_cnt    from edge_bit_cnt
//   cnt_en               enable to edge_bit_cnt; low clears it
//   p_data, data_valid   received byte and its 1-cycle strobe
//   par_err, stp_err     1-cycle error strobes at frame end
//   busy                 high whenever not IDLE
module uart_rx_ctrl
    import uart_rx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               par_en,
    input  logic               par_typ,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic [BIT_W-1:0]   bit_cnt,
    output logic               cnt_en,
    output logic [DATA_W-1:0]  p_data,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err,
    output logic               busy
);

    rx_state_e          state_q, state_d;
    logic [PRESC_W-1:0] prescale_q, prescale_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_flag_q, par_flag_d;
    logic               cnt_en_q, cnt_en_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  p_data_q, p_data_d;
    logic               data_valid_q, data_valid_d;
    logic               par_err_q, par_err_d;
    logic               stp_err_q, stp_err_d;

    logic               vote;
    logic               bit_end;

    rx_majority_sampler u_sampler (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .edge_cnt (edge_cnt),
        .prescale (prescale_q),
        .vote_c   (vote)
    );

    // Last oversample tick of a bit; only meaningful while the counter runs.
    assign bit_end = cnt_en_q && (edge_cnt == prescale_q - PRESC_W'(1));

    // Next-state, deserialiser and strobe generation.
    always_comb begin
        state_d      = state_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        shift_d      = shift_q;
        par_flag_d   = par_flag_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_in) begin
                    state_d    = ST_START;
                    prescale_d = prescale;
                    par_en_d   = par_en;
                    par_typ_d  = par_typ;
                    shift_d    = '0;
                    par_flag_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) state_d = vote ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {vote, shift_q[DATA_W-1:1]};
                    if (bit_cnt == BIT_W'(DATA_W))
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    par_flag_d = (^shift_q) ^ vote ^ par_typ_q;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
`ifdef RX_ERR_CHECK_EN
                    stp_err_d = ~vote;
                    par_err_d = par_flag_q & par_en_q;
                    if (vote && !(par_flag_q && par_en_q)) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
`else
                    p_data_d     = shift_q;
                    data_valid_d = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping cnt_en for the IDLE cycle clears edge_bit_cnt between frames.
        cnt_en_d = (state_d != ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
    end

`ifndef RX_ERR_CHECK_EN
    logic unused_par;
    assign unused_par = par_flag_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            shift_q      <= '0;
            par_flag_q   <= 1'b0;
            cnt_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            shift_q      <= shift_d;
            par_flag_q   <= par_flag_d;
            cnt_en_q     <= cnt_en_d;
            busy_q       <= busy_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign cnt_en     = cnt_en_q;
    assign busy       = busy_q;
    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule
